// File: rtl/regfile_wb_pkg.sv
// Shared types and widths for the regfile writeback queue.
// REG_NUM and DATA_WIDTH are fixed here so the entry struct and every
// user of it agree on field widths.
package regfile_wb_pkg;

  localparam int REG_NUM    = 32;
  localparam int AW         = $clog2(REG_NUM);
  localparam int DATA_WIDTH = 32;

  typedef struct packed {
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_bypass_match.sv
// Bypass lookup for one read port: finds the youngest valid queued entry
// whose destination matches the lookup address.
// Entries arrive age-ordered: index 0 is the oldest, DEPTH-1 the youngest slot.
module wb_bypass_match
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]      i_valid,
  input  wb_req_t [DEPTH-1:0]   i_entries,
  input  logic [AW-1:0]         i_addr,
  output logic                  o_hit,
  output logic [DATA_WIDTH-1:0] o_data
);

  // Youngest-first priority search; the first match found wins.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (!o_hit && i_valid[j] && (i_entries[j].addr == i_addr)) begin
        o_hit  = 1'b1;
        o_data = i_entries[j].data;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback queue feeding the regfile write ports.
// Buffers execute-stage results and drains up to WRITE_PORTS oldest entries
// per cycle; port 0 always carries the oldest, so same-address writes drained
// together resolve youngest-wins in the regfile.
// Optional feature: define REGFILE_WB_BYPASS_EN to enable the bypass lookup
// of still-queued values; otherwise lookup outputs are tied to zero.
// REG_NUM and DATA_WIDTH come from regfile_wb_pkg.
module regfile_wb_queue
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int WRITE_PORTS = 1,
  parameter int READ_PORTS  = 2,
  parameter int ZERO_KEEP   = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_in_valid,
  output logic                                   o_in_ready,
  input  logic [AW-1:0]                          i_in_addr,
  input  logic [DATA_WIDTH-1:0]                  i_in_data,
  input  logic                                   i_drain_en,
  output logic [WRITE_PORTS-1:0]                 o_we,
  output logic [WRITE_PORTS-1:0][AW-1:0]         o_waddr,
  output logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] o_wdata,
  input  logic [READ_PORTS-1:0][AW-1:0]          i_lookup_addr,
  output logic [READ_PORTS-1:0]                  o_lookup_hit,
  output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  o_lookup_data,
  output logic [$clog2(DEPTH+1)-1:0]             o_count,
  output logic                                   o_empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  wb_req_t       r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_accept;
  logic          w_store;
  logic [CW-1:0] w_n;

  assign o_in_ready = (r_count != CW'(DEPTH));
  assign o_count    = r_count;
  assign o_empty    = (r_count == '0);

  // Hard-zero destinations complete the handshake but are never stored.
  assign w_accept = i_in_valid && o_in_ready;
  assign w_store  = w_accept && (int'(i_in_addr) >= ZERO_KEEP);

  assign w_n = !i_drain_en               ? '0 :
               (r_count < CW'(WRITE_PORTS)) ? r_count : CW'(WRITE_PORTS);

  // Write ports show the oldest w_n entries; suppressed while in reset.
  always_comb begin
    o_we    = '0;
    o_waddr = '0;
    o_wdata = '0;
    for (int k = 0; k < WRITE_PORTS; k++) begin
      o_we[k]    = !rst && (k < int'(w_n));
      o_waddr[k] = r_mem[r_head + PW'(k)].addr;
      o_wdata[k] = r_mem[r_head + PW'(k)].data;
    end
  end

  // Entry storage, intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[r_tail] <= '{addr: i_in_addr, data: i_in_data};
    end
  end

  // Pointer and occupancy update; pop and push may happen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_n);
      if (w_store) begin
        r_tail <= r_tail + 1'b1;
      end
      r_count <= r_count + CW'(w_store) - w_n;
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  wb_req_t [DEPTH-1:0] w_age_entries;
  logic [DEPTH-1:0]    w_age_valid;

  // Present storage oldest-first so the matcher can prioritise by age.
  always_comb begin
    w_age_entries = '0;
    w_age_valid   = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_age_entries[j] = r_mem[r_head + PW'(j)];
      w_age_valid[j]   = (j < int'(r_count));
    end
  end

  for (genvar i = 0; i < READ_PORTS; i++) begin : g_match
    wb_bypass_match #(.DEPTH(DEPTH)) u_match (
      .i_valid   (w_age_valid),
      .i_entries (w_age_entries),
      .i_addr    (i_lookup_addr[i]),
      .o_hit     (o_lookup_hit[i]),
      .o_data    (o_lookup_data[i])
    );
  end
`else
  logic w_unused_lookup;
  assign w_unused_lookup = ^i_lookup_addr;
  assign o_lookup_hit    = '0;
  assign o_lookup_data   = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: a one-port and a two-port instance, each
// checked against a queue-based model of the writeback buffer.
module tb_regfile_wb_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t q1[$];
  ent_t q2[$];

  // one write port instance
  logic              i1_valid = 0, i1_drain = 0;
  logic [4:0]        i1_addr = 0;
  logic [31:0]       i1_data = 0;
  logic              o1_ready, o1_empty;
  logic [0:0]        o1_we;
  logic [0:0][4:0]   o1_waddr;
  logic [0:0][31:0]  o1_wdata;
  logic [1:0][4:0]   i1_lk = '0;
  logic [1:0]        o1_hit;
  logic [1:0][31:0]  o1_ldata;
  logic [2:0]        o1_count;

  // two write port instance
  logic              i2_valid = 0, i2_drain = 0;
  logic [4:0]        i2_addr = 0;
  logic [31:0]       i2_data = 0;
  logic              o2_ready, o2_empty;
  logic [1:0]        o2_we;
  logic [1:0][4:0]   o2_waddr;
  logic [1:0][31:0]  o2_wdata;
  logic [1:0][4:0]   i2_lk = '0;
  logic [1:0]        o2_hit;
  logic [1:0][31:0]  o2_ldata;
  logic [2:0]        o2_count;

  regfile_wb_queue #(.DEPTH(4), .WRITE_PORTS(1), .READ_PORTS(2), .ZERO_KEEP(1)) dut1 (
    .clk(clk), .rst(rst), .i_in_valid(i1_valid), .o_in_ready(o1_ready),
    .i_in_addr(i1_addr), .i_in_data(i1_data), .i_drain_en(i1_drain),
    .o_we(o1_we), .o_waddr(o1_waddr), .o_wdata(o1_wdata),
    .i_lookup_addr(i1_lk), .o_lookup_hit(o1_hit), .o_lookup_data(o1_ldata),
    .o_count(o1_count), .o_empty(o1_empty)
  );

  regfile_wb_queue #(.DEPTH(4), .WRITE_PORTS(2), .READ_PORTS(2), .ZERO_KEEP(1)) dut2 (
    .clk(clk), .rst(rst), .i_in_valid(i2_valid), .o_in_ready(o2_ready),
    .i_in_addr(i2_addr), .i_in_data(i2_data), .i_drain_en(i2_drain),
    .o_we(o2_we), .o_waddr(o2_waddr), .o_wdata(o2_wdata),
    .i_lookup_addr(i2_lk), .o_lookup_hit(o2_hit), .o_lookup_data(o2_ldata),
    .o_count(o2_count), .o_empty(o2_empty)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // youngest queued value for an address, as the bypass should report it
  task automatic model_lookup(input logic [4:0] la, output logic hit, output logic [31:0] dat);
    hit = 1'b0;
    dat = '0;
`ifdef REGFILE_WB_BYPASS_EN
    foreach (q1[i]) begin
      if (q1[i].a == la) begin
        hit = 1'b1;
        dat = q1[i].d;
      end
    end
`endif
  endtask

  // one cycle on the single-port instance (called at posedge+1)
  task automatic step1(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic dr, input logic [4:0] l0, input logic [4:0] l1);
    logic rdy, eh;
    logic [31:0] ed;
    int n;
    i1_valid = v; i1_addr = a; i1_data = d; i1_drain = dr;
    i1_lk[0] = l0; i1_lk[1] = l1;
    i2_valid = 0; i2_drain = 0;
    @(negedge clk);
    rdy = (q1.size() != 4);
    n   = (dr && q1.size() > 0) ? 1 : 0;
    check("ready1", o1_ready, rdy);
    check("count1", o1_count, q1.size());
    check("empty1", o1_empty, q1.size() == 0);
    check("we1", o1_we, n);
    if (n == 1) begin
      check("waddr1", o1_waddr[0], q1[0].a);
      check("wdata1", o1_wdata[0], q1[0].d);
    end
    model_lookup(l0, eh, ed);
    check("hit1_0", o1_hit[0], eh);
    check("ldata1_0", o1_ldata[0], ed);
    model_lookup(l1, eh, ed);
    check("hit1_1", o1_hit[1], eh);
    check("ldata1_1", o1_ldata[1], ed);
    @(posedge clk);
    if (n == 1) void'(q1.pop_front());
    if (v && rdy && a != 0) q1.push_back('{a: a, d: d});
    #1;
  endtask

  // one cycle on the two-port instance
  task automatic step2(input logic v, input logic [4:0] a, input logic [31:0] d, input logic dr);
    logic rdy;
    int n;
    i2_valid = v; i2_addr = a; i2_data = d; i2_drain = dr;
    i1_valid = 0; i1_drain = 0;
    @(negedge clk);
    rdy = (q2.size() != 4);
    n   = dr ? ((q2.size() < 2) ? q2.size() : 2) : 0;
    check("ready2", o2_ready, rdy);
    check("count2", o2_count, q2.size());
    for (int k = 0; k < 2; k++) begin
      check($sformatf("we2_%0d", k), o2_we[k], k < n);
      if (k < n) begin
        check($sformatf("waddr2_%0d", k), o2_waddr[k], q2[k].a);
        check($sformatf("wdata2_%0d", k), o2_wdata[k], q2[k].d);
      end
    end
    @(posedge clk);
    repeat (n) void'(q2.pop_front());
    if (v && rdy && a != 0) q2.push_back('{a: a, d: d});
    #1;
  endtask

  // one reset cycle; write enables must stay low even with entries queued
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    check("rst_we1", o1_we, 0);
    check("rst_we2", o2_we, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q1.delete();
    q2.delete();
  endtask

  initial begin
    do_reset();
    step1(0, 0, 0, 1, 5, 0);

    // single write, visible the next cycle
    step1(1, 5, 32'hDEAD_BEEF, 1, 5, 6);
    step1(0, 0, 0, 1, 5, 0);
    step1(0, 0, 0, 1, 5, 0);

    // fill while held, overflow attempt, then drain in order
    for (int i = 1; i <= 4; i++) step1(1, 5'(i), 32'h100 + i, 0, 5'(i), 3);
    step1(1, 9, 32'h999, 0, 9, 4);
    for (int i = 0; i < 5; i++) step1(0, 0, 0, 1, 4, 9);

    // hard-zero destination
    step1(1, 0, 32'h1234, 1, 0, 0);
    step1(0, 0, 0, 1, 0, 0);
    step1(0, 0, 0, 1, 0, 0);

    // continuous enqueue+drain across pointer wrap
    for (int i = 0; i < 10; i++) step1(1, 5'(10 + i), 32'hA000 + i, 1, 5'(10 + i), 5'(9 + i));
    step1(0, 0, 0, 1, 0, 0);

    // bypass: youngest wins, miss on another address
    step1(1, 7, 1, 0, 7, 8);
    step1(1, 7, 2, 0, 7, 8);
    step1(0, 0, 0, 0, 7, 8);
    step1(0, 0, 0, 1, 7, 8);
    step1(0, 0, 0, 1, 7, 8);
    step1(0, 0, 0, 1, 7, 8);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      step1($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) != 0, 5'($urandom_range(0, 8)), 5'($urandom_range(0, 8)));
    end

    // reset in the middle of a fill
    for (int i = 0; i < 3; i++) step1(1, 5'(20 + i), 32'hC0 + i, 0, 20, 21);
    i1_drain = 1'b1;
    do_reset();
    step1(0, 0, 0, 1, 20, 21);
    step1(0, 0, 0, 1, 20, 21);

    // two write ports: same-address pair drained together, oldest on port 0
    step2(1, 3, 32'hAAAA, 0);
    step2(1, 3, 32'hBBBB, 0);
    step2(0, 0, 0, 1);
    step2(0, 0, 0, 1);
    for (int i = 0; i < 200; i++) begin
      step2($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 3; i++) step2(1, 5'(1 + i), 32'hE0 + i, 0);
    i2_drain = 1'b1;
    do_reset();
    step2(0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
